// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD host: default widths and FSM state encoding.
package gcd_pkg;

   // Default operand/result width and WAIT-state abort limit.
   localparam int GCD_W       = 4;
   localparam int GCD_TIMEOUT = 31;

   // FSM state encoding kept as plain constants so older tools can use them too.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   // Named view of the same encoding, handy for debug and waveform decoding.
   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      LOAD = ST_LOAD,
      WAIT = ST_WAIT,
      HOLD = ST_HOLD
   } gcd_state_e;

endpackage

// File: rtl/gcd_host.sv
// Host controller for an external GCD engine: accepts an operand pair,
// short-circuits zero operands, otherwise loads the engine, waits for its
// result with a timeout, and holds the result until the consumer takes it.
import gcd_pkg::*;

module gcd_host #(
   parameter int W       = GCD_W,
   parameter int TIMEOUT = GCD_TIMEOUT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         run,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_x,
   input  logic [W-1:0] in_y,
   output logic         eng_rst,
   output logic [W-1:0] eng_xin,
   output logic [W-1:0] eng_yin,
   input  logic [W-1:0] eng_gcd,
   input  logic         eng_done,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] res_gcd,
   output logic         res_err,
   output logic         busy
);

   // Counter wide enough to reach TIMEOUT without wrapping.
   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   logic [1:0]    state_q,   state_d;
   logic [CW-1:0] cnt_q,     cnt_d;
   logic [W-1:0]  op_x_q,    op_x_d;
   logic [W-1:0]  op_y_q,    op_y_d;
   logic [W-1:0]  res_gcd_q, res_gcd_d;
   logic          res_err_q, res_err_d;
   logic          accept;

   // Status outputs are decoded from state only; in_ready is also masked by
   // rst so nothing can be offered as accepted while reset is asserted.
   assign in_ready  = run && !rst && (state_q == ST_IDLE);
   assign accept    = in_valid && in_ready;
   assign busy      = (state_q != ST_IDLE);
   assign res_valid = (state_q == ST_HOLD);
   assign eng_rst   = (state_q != ST_WAIT);
   assign eng_xin   = op_x_q;
   assign eng_yin   = op_y_q;
   assign res_gcd   = res_gcd_q;
   assign res_err   = res_err_q;

   // Next-state and datapath update for the IDLE/LOAD/WAIT/HOLD sequence.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_x_d    = op_x_q;
      op_y_d    = op_y_q;
      res_gcd_d = res_gcd_q;
      res_err_d = res_err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_x_d = in_x;
               op_y_d = in_y;
               // A zero operand makes the gcd the other operand (gcd(0,0)=0);
               // the subtractive engine would never converge on it.
               if ((in_x == '0) || (in_y == '0)) begin
                  res_gcd_d = in_x | in_y;
                  res_err_d = 1'b0;
                  state_d   = ST_HOLD;
               end else begin
                  state_d   = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            // Engine captures operands here while still parked.
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            // Engine completion takes priority over a simultaneous timeout.
            if (eng_done) begin
               res_gcd_d = eng_gcd;
               res_err_d = 1'b0;
               state_d   = ST_HOLD;
            end else if (cnt_q == CW'(TIMEOUT)) begin
               res_gcd_d = '0;
               res_err_d = 1'b1;
               state_d   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and data registers; reset aborts any operation in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_x_q    <= '0;
         op_y_q    <= '0;
         res_gcd_q <= '0;
         res_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_x_q    <= op_x_d;
         op_y_q    <= op_y_d;
         res_gcd_q <= res_gcd_d;
         res_err_q <= res_err_d;
      end
   end

endmodule

// File: tb/tb_gcd_host.sv
// Bench for gcd_host paired with a behavioural subtractive GCD engine,
// which can be switched into a never-done stub to force the timeout path.
module tb_gcd_host;

   localparam int W       = 4;
   localparam int TIMEOUT = 31;

   typedef struct packed {
      logic [W-1:0] g;
      logic         e;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         run;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_x;
   logic [W-1:0] in_y;
   logic         eng_rst;
   logic [W-1:0] eng_xin;
   logic [W-1:0] eng_yin;
   logic [W-1:0] eng_gcd;
   logic         eng_done;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] res_gcd;
   logic         res_err;
   logic         busy;

   logic         stub_mode;
   logic [W-1:0] ex_q;
   logic [W-1:0] ey_q;
   int           wait_cycles = 0;
   int           checks      = 0;
   int           failures    = 0;
   exp_t         sb[$];

   always #5 clk = ~clk;

   gcd_host #(.W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .eng_rst   (eng_rst),
      .eng_xin   (eng_xin),
      .eng_yin   (eng_yin),
      .eng_gcd   (eng_gcd),
      .eng_done  (eng_done),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_gcd   (res_gcd),
      .res_err   (res_err),
      .busy      (busy)
   );

   // Subtractive GCD engine: loads while eng_rst is high, then subtracts
   // the smaller value from the larger until both are equal.
   always_ff @(posedge clk) begin
      if (eng_rst) begin
         ex_q <= eng_xin;
         ey_q <= eng_yin;
      end else if (ex_q > ey_q) begin
         ex_q <= ex_q - ey_q;
      end else if (ey_q > ex_q) begin
         ey_q <= ey_q - ex_q;
      end
   end
   assign eng_gcd  = ex_q;
   assign eng_done = !eng_rst && !stub_mode && (ex_q == ey_q);

   // Counts clock cycles in which the engine was released (WAIT cycles).
   always @(posedge clk) begin
      if (eng_rst === 1'b0) wait_cycles <= wait_cycles + 1;
   end

   function automatic logic [W-1:0] ref_gcd(input int a_in, input int b_in);
      int a, b, t;
      a = a_in;
      b = b_in;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a[W-1:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // Drive one request, wait for the result, hold it for hold_cyc cycles
   // with res_ready low, then hand it off and compare against the scoreboard.
   task automatic run_req(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic timeout_exp, input int hold_cyc,
                          input int exp_wait);
      exp_t e;
      exp_t got_e;
      bit   got;
      int   lat;
      int   w0;
      int   wc;
      bit   bypass;
      bypass = (x == '0) || (y == '0);
      e.g = timeout_exp ? '0 : ref_gcd(int'(x), int'(y));
      e.e = timeout_exp;
      sb.push_back(e);

      @(negedge clk);
      in_x     = x;
      in_y     = y;
      in_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         if (in_ready === 1'b1) got = 1'b1;
         else @(negedge clk);
      end
      check("accept", 32'(got), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      w0 = wait_cycles;

      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (res_valid === 1'b1) got = 1'b1;
         else lat++;
      end
      check("res_valid_seen", 32'(got), 32'd1);
      wc = wait_cycles - w0;

      if (got) begin
         check("wait_cycles", wc, exp_wait);
         check("latency", lat, bypass ? 0 : exp_wait + 1);
         for (int i = 0; i < hold_cyc; i++) begin
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_gcd", 32'(res_gcd), 32'(e.g));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
         end
         res_ready = 1'b1;
         got_e = sb.pop_front();
         check("res_gcd", 32'(res_gcd), 32'(got_e.g));
         check("res_err", 32'(res_err), 32'(got_e.e));
         check("hold_busy", 32'(busy), 32'd1);
         @(negedge clk);
         res_ready = 1'b0;
         check("post_valid", 32'(res_valid), 32'd0);
         check("post_busy", 32'(busy), 32'd0);
         check("post_in_ready", 32'(in_ready), 32'(run));
      end else begin
         void'(sb.pop_front());
      end
   endtask

   initial begin
      bit seen;
      rst       = 1'b1;
      run       = 1'b1;
      in_valid  = 1'b0;
      in_x      = '0;
      in_y      = '0;
      res_ready = 1'b0;
      stub_mode = 1'b0;

      // Reset state, with run already high.
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_gcd", 32'(res_gcd), 32'd0);
      check("rst_res_err", 32'(res_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_eng_rst", 32'(eng_rst), 32'd1);
      check("rst_eng_xin", 32'(eng_xin), 32'd0);
      rst = 1'b0;
      #1;
      check("first_in_ready", 32'(in_ready), 32'd1);

      // Normal engine path: three subtract/compare cycles.
      run_req(4'd12, 4'd8, 1'b0, 0, 3);
      // Zero-operand bypass paths never release the engine.
      run_req(4'd0, 4'd9, 1'b0, 0, 0);
      run_req(4'd0, 4'd0, 1'b0, 0, 0);

      // run low blocks acceptance.
      @(negedge clk);
      run      = 1'b0;
      in_x     = 4'd5;
      in_y     = 4'd0;
      in_valid = 1'b1;
      #1;
      check("run_low_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("run_low_busy", 32'(busy), 32'd0);
      check("run_low_valid", 32'(res_valid), 32'd0);
      in_valid = 1'b0;
      run      = 1'b1;

      // Result held stable while the consumer stalls.
      run_req(4'd15, 4'd10, 1'b0, 5, 3);

      // Engine that never finishes: abort after the counter reaches TIMEOUT.
      stub_mode = 1'b1;
      run_req(4'd3, 4'd5, 1'b1, 0, TIMEOUT + 1);
      stub_mode = 1'b0;

      // Reset in the middle of WAIT discards the operation.
      @(negedge clk);
      in_x     = 4'd13;
      in_y     = 4'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (eng_rst === 1'b0) seen = 1'b1;
      end
      check("mid_wait_reached", 32'(seen), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_valid", 32'(res_valid), 32'd0);
      check("mid_rst_eng_rst", 32'(eng_rst), 32'd1);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("after_rst_valid", 32'(res_valid), 32'd0);
      end
      run_req(4'd6, 4'd9, 1'b0, 0, 3);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
